// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N producer channels in, one registered beat out.
interface mux_arb_n_if #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, mode, sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, mode, sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-channel registered mux/arbiter with one-entry output register.
// Round-robin mode and its pointer exist only when MUX_ARB_RR_EN is defined.
module mux_arb_n_lane #(
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            en,
  input  logic [SELW-1:0] grant_idx,
  output logic            ready
);
  assign ready = en & (grant_idx == SELW'(IDX));
endmodule

module mux_arb_n #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_arb_n_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t                 state, state_nxt;
  logic [N-1:0][WIDTH-1:0] data_arr;
  logic [WIDTH-1:0]       data_q;
  logic [SELW-1:0]        sel_q;
  logic [SELW-1:0]        grant_idx;
  logic                   grant_vld;
  logic                   load_ok;
  logic                   xfer;

  assign data_arr = bus.in_data;
  assign load_ok  = (state == EMPTY) | bus.out_ready;
  assign xfer     = load_ok & grant_vld;

`ifdef MUX_ARB_RR_EN
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] cand;

  // Walk offsets high to low so the channel nearest ptr is written last and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = bus.sel;
    cand      = '0;
    if (bus.mode) begin
      for (int k = N-1; k >= 0; k--) begin
        cand = ptr + SELW'(k);
        if (bus.in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end else begin
      grant_vld = bus.in_valid[bus.sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ptr <= '0;
    else if (xfer & bus.mode) ptr <= grant_idx + SELW'(1);
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;

  always_comb begin
    grant_idx = bus.sel;
    grant_vld = bus.in_valid[bus.sel];
  end
`endif

  // in_ready is gated by rst_n so it drops immediately on reset assertion.
  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_arb_n_lane #(.SELW(SELW), .IDX(i)) u_lane (
      .en        (rst_n & xfer),
      .grant_idx (grant_idx),
      .ready     (bus.in_ready[i])
    );
  end

  always_comb begin
    state_nxt = state;
    if (load_ok) state_nxt = grant_vld ? FULL : EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (xfer) begin
      data_q <= data_arr[grant_idx];
      sel_q  <= grant_idx;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n (N=4, WIDTH=8); RR steps only when MUX_ARB_RR_EN is defined.
module tb_mux_arb_n;
  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mux_arb_n_if #(.WIDTH(WIDTH), .N(N)) bus ();

  mux_arb_n #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v));
    chk({tag, ".out_data"},  64'(bus.out_data),  64'(d));
    chk({tag, ".out_sel"},   64'(bus.out_sel),   64'(s));
  endtask

  initial begin
    bus.in_valid  = 4'b1111;
    bus.in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
    bus.mode      = 1'b0;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;
    #2;
    // held in reset: nothing granted even though channel 0 is valid
    chk_out("rst0", 1'b0, 8'h00, 2'd0);
    chk("rst0.in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    rst_n = 1'b1;

    // fixed select sel=2
    bus.sel = 2'd2;
    #1 chk("fix.in_ready", 64'(bus.in_ready), 64'b0100);
    tick();
    chk_out("fix", 1'b1, 8'hA5, 2'd2);

    // fixed select with sel invalid, others valid: drain, no grant
    bus.in_valid = 4'b1011;
    #1 chk("fixnone.in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    chk("fixnone.out_valid", 64'(bus.out_valid), 64'h0);

    // load channel 1, then backpressure for 3 cycles
    bus.sel = 2'd1;
    bus.in_valid = 4'b0010;
    #1 chk("bp.load.in_ready", 64'(bus.in_ready), 64'b0010);
    tick();
    chk_out("bp.load", 1'b1, 8'h22, 2'd1);
    bus.out_ready = 1'b0;
    bus.in_data   = {8'h44, 8'hA5, 8'h99, 8'h11};
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i == 0) ? 4'b1111 : (i == 1) ? 4'b0110 : 4'b0010;
      #1 chk("bp.hold.in_ready", 64'(bus.in_ready), 64'h0);
      tick();
      chk_out("bp.hold", 1'b1, 8'h22, 2'd1);
    end
    // release: drain and load channel 3 in the same cycle
    bus.out_ready = 1'b1;
    bus.sel = 2'd3;
    bus.in_valid = 4'b1000;
    #1 chk("bp.rel.in_ready", 64'(bus.in_ready), 64'b1000);
    tick();
    chk_out("bp.rel", 1'b1, 8'h44, 2'd3);

`ifdef MUX_ARB_RR_EN
    // round-robin from ptr=0, all valid
    bus.mode = 1'b1;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr.in_ready", 64'(bus.in_ready), 64'(4'b0001 << (i % 4)));
      tick();
      chk("rr.out_sel", 64'(bus.out_sel), 64'(i % 4));
    end
    // ptr=1 now; skip 1,2 to reach 3, then wrap to 0
    bus.in_valid = 4'b1001;
    #1 chk("rrskip.in_ready3", 64'(bus.in_ready), 64'b1000);
    tick();
    chk_out("rrskip3", 1'b1, 8'h44, 2'd3);
    #1 chk("rrskip.in_ready0", 64'(bus.in_ready), 64'b0001);
    tick();
    chk_out("rrskip0", 1'b1, 8'h11, 2'd0);
`else
    // mode ignored: only sel channel 3 is ever granted
    bus.mode = 1'b1;
    bus.sel = 2'd3;
    bus.in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      #1 chk("noRR.in_ready", 64'(bus.in_ready), 64'b1000);
      tick();
      chk_out("noRR", 1'b1, 8'h44, 2'd3);
    end
`endif

    // asynchronous reset mid-stream while FULL
    chk("mid.pre.out_valid", 64'(bus.out_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
    chk("midrst.in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    rst_n = 1'b1;
    bus.mode = 1'b0;
    bus.in_valid = 4'b0000;
    tick();
    chk_out("postrst", 1'b0, 8'h00, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised successor to the 4:1 single-bit mux: an N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes, a fixed-select or round-robin grant mode, and a one-entry output register. It sits between competing producers (forwarding sources, writeback ports, memory responses) and a single consumer in the ARM datapath. It delivers one selected beat per cycle at full throughput with one cycle of latency.

## Interface
Parameters:
- WIDTH, 64, data bits per channel (≥1).
- N, 4, channel count (power of two, ≥2).
- SELW, $clog2(N), derived select width; never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N  channel i offers a beat.
- in_data  in  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_ready  out  N  channel i beat accepted this cycle; one-hot or zero.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used in fixed mode.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered beat.
- out_sel  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the beat when out_valid=1.

## Operation
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_ok = !out_valid | out_ready.
- Grant, combinational, at most one channel:
  - Fixed mode: grant = sel if in_valid[sel], otherwise none. Other channels are never granted, even if valid.
  - Round-robin mode: grant = first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- in_ready[i] = load_ok & (grant == i). A transfer occurs when in_valid[i] & in_ready[i].
- On transfer: out_data ← channel data, out_sel ← i, out_valid ← 1.
- If load_ok and no grant: out_valid ← 0 (FULL drains to EMPTY, or stays EMPTY).
- If FULL and !out_ready: hold out_valid, out_data, and out_sel; all in_ready = 0.
- RR pointer ptr (SELW bits):
  - On a transfer in round-robin mode: ptr ← (grant+1) mod N. N-1 wraps to 0.
  - Otherwise ptr holds, including all cycles in fixed mode.
- Handshake rules:
  - Producers must hold in_data stable while in_valid=1 and unaccepted.
  - out_data and out_sel are stable while out_valid=1 & !out_ready.
- mode and sel are sampled combinationally each cycle; a change affects the next grant only. It never disturbs a held beat.

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready is 0 while rst_n=0.
- Latency: a beat accepted in cycle t appears on out_valid/out_data in cycle t+1.
- Throughput: one beat per cycle when out_ready is held high. Drain and load in the same cycle are allowed, with no bubble.
- Backpressure: out_ready=0 with FULL gives in_ready=0 in that same cycle (combinational path out_ready→in_ready).
- Reset mid-operation drops the held beat. No beat is reported after reset release until a new transfer.
- Fixed mode with in_valid[sel]=0 and other channels valid: no transfer, and out_valid drops after the drain.

## Configuration
- MUX_ARB_RR_EN:
  - Defined: round-robin mode and the ptr register are compiled in; mode selects between fixed and round-robin.
  - Undefined: the mode input is ignored (treated as 0), no ptr flop is instantiated, and only fixed select is available. The port list is unchanged.

## Test plan
- Reset: rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately, without waiting for a clk edge.
- Fixed select, N=4, WIDTH=8: sel=2, in_valid=4'b1111, in_data[2]=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
- Round-robin fairness (MUX_ARB_RR_EN): mode=1, all valid, out_ready=1 for 5 cycles → out_sel sequence 0,1,2,3,0; ptr wraps from 3 to 0.
- RR skip: ptr=1, in_valid=4'b1001 → grant 3, then ptr=0 → grant 0.
- Backpressure: FULL with out_sel=1, out_ready=0 for 3 cycles while in_valid changes → in_ready=0, out_data/out_sel unchanged; on out_ready=1, drain and next load occur in the same cycle.
- Macro off: mode=1, sel=3, in_valid=4'b1001 → only channel 3 is granted each cycle; channel 0 is never accepted.
